// File: rtl/fifo_queue.sv
// Synchronous show-ahead FIFO with occupancy count, flush and sticky
// overflow/underflow flags. Full/empty come from the count, not pointer equality.
module fifo_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst,
  input  logic                  in_flush,
  input  logic                  in_push,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_full,
  output logic                  out_empty,
  output logic [PTR_WIDTH:0]    out_count,
  output logic                  out_overflow,
  output logic                  out_underflow
);

  localparam logic [PTR_WIDTH:0] DEPTH_CNT = FIFO_DEPTH[PTR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty, push_ok, pop_ok;

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = in_push & (~full | in_pop);
  assign pop_ok  = in_pop & ~empty;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (in_flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_d = count_q - 1'b1;
      end
      if (in_push && !push_ok) begin
        overflow_d = 1'b1;
      end
      if (in_pop && !pop_ok) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Storage is not cleared on reset; out_data is masked while empty instead.
  always_ff @(posedge in_Clk) begin
    mem_q <= mem_d;
    if (in_Rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_data      = empty ? '0 : mem_q[rd_ptr_q];
  assign out_full      = full;
  assign out_empty     = empty;
  assign out_count     = count_q;
  assign out_overflow  = overflow_q;
  assign out_underflow = underflow_q;

endmodule

// File: doc/fifo_queue.md
# fifo_queue

Synchronous first-in-first-out buffer: entries leave from the opposite end from which they entered, so it complements the LIFO stack primitive. It is used wherever ordering must be preserved, such as the fetch-to-decode instruction queue and the store buffer ahead of the data memory port. The block has a show-ahead read port, an occupancy count, a flush, and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 64, entry width in bits
- FIFO_DEPTH, 16, number of entries; must be a power of two, ≥ 2
- PTR_WIDTH, 4, log2(FIFO_DEPTH)

- in_Clk  input  1  clock; all state updates on rising edge
- in_Rst  input  1  reset, synchronous, active-high
- in_flush  input  1  discard all entries this cycle
- in_push  input  1  write request
- in_data  input  DATA_WIDTH  write data
- in_pop  input  1  read/consume request
- out_data  output  DATA_WIDTH  oldest entry (show-ahead); 0 when empty
- out_full  output  1  count == FIFO_DEPTH
- out_empty  output  1  count == 0
- out_count  output  PTR_WIDTH+1  occupancy, 0..FIFO_DEPTH
- out_overflow  output  1  sticky: a push was dropped because the FIFO was full
- out_underflow  output  1  sticky: a pop was dropped because the FIFO was empty

## Operation
- State:
  - write pointer wr_ptr (PTR_WIDTH)
  - read pointer rd_ptr (PTR_WIDTH)
  - count (PTR_WIDTH+1)
  - storage mem[FIFO_DEPTH]
- Pointers wrap modulo FIFO_DEPTH by natural overflow. Full and empty are decided from count, never from pointer equality alone.
- All FIFO_DEPTH entries are usable.
- push_ok = in_push & (!out_full | in_pop).
- pop_ok = in_pop & !out_empty.
- push_ok: mem[wr_ptr] ← in_data; wr_ptr += 1.
- pop_ok: rd_ptr += 1.
- count update:
  - +1 if push_ok only
  - −1 if pop_ok only
  - unchanged if both or neither
- Full with push+pop: both are accepted. The oldest entry leaves, the new entry goes to the slot at wr_ptr (which equals rd_ptr), and count stays FIFO_DEPTH.
- Empty with push+pop: the pop is dropped and flagged as underflow, the push is accepted, and count becomes 1. There is no bypass: out_data shows the new entry from the next cycle.
- Dropped push (full, no pop): out_overflow ← 1. Dropped pop (empty): out_underflow ← 1. Both flags hold until reset or flush.
- out_data = mem[rd_ptr] when count ≠ 0, else 0. This is combinational from registers, with no path from in_data.
- Priority: in_Rst > in_flush > push/pop.
  - Flush sets wr_ptr, rd_ptr and count to 0, clears both sticky flags, and ignores in_push/in_pop that cycle.
  - mem contents are left stale.
- Reset has the same effect as flush. Clearing mem is not required; out_data is 0 whenever empty.

## Timing
- Reset values (cycle after in_Rst sampled high):
  - out_empty 1, out_full 0, out_count 0
  - out_data 0
  - out_overflow 0, out_underflow 0
- Reset mid-operation discards all entries at that edge. Any push or pop asserted in the same cycle is ignored.
- Write latency: data pushed at edge N is visible on out_data after edge N if the FIFO was empty, otherwise once it becomes oldest.
- Pop: out_data advances to the next entry, or to 0 if the FIFO empties, after the popping edge.
- out_full, out_empty and out_count reflect the post-edge state. There is no combinational dependence on in_push/in_pop.
- Sustained simultaneous push+pop at any occupancy ≥ 1 gives throughput of one entry per cycle.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop 3 times.
  - out_data sequence: 0x11, 0x22, 0x33, then 0.
  - out_count steps 1, 2, 3, then 2, 1, 0; out_empty returns to 1.
- Push 16 entries (0..15), then push 0xAA alone.
  - out_full=1, out_count=16, out_overflow=1.
  - Popping 16 times yields 0..15; 0xAA is never seen.
- Full FIFO, push 0xBB with pop in the same cycle.
  - out_count stays 16 and out_data becomes 1.
  - After 15 more pops, out_data = 0xBB.
- Empty FIFO, push 0x5 with pop in the same cycle.
  - Next cycle: out_count=1, out_data=0x5, out_underflow=1.
- Wrap-around: run 40 cycles of push+pop with occupancy held at 3, using incrementing data.
  - Output order matches input exactly with no gaps; pointers have wrapped twice.
- Load 5 entries with out_overflow set, then assert in_flush together with in_push.
  - Next cycle: out_empty=1, out_count=0, out_data=0, both flags 0.
- Repeat the same stimulus with in_Rst instead of in_flush; the result is identical.
